// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset vector, canonical nop and next-PC selector encoding.
package cpu_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP              = '0;

  typedef enum logic [2:0] {
    PC4,
    BR,
    J,
    JR,
    HOLD
  } npc_sel_t;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bundle: redirect inputs from D, instruction-memory port and F/D outputs.
interface fetch_pc_unit_if;

  logic        stall_i;
  logic        br_taken_i;
  logic [31:0] br_target_i;
  logic        j_i;
  logic [31:0] j_target_i;
  logic        jr_i;
  logic [31:0] jr_target_i;
  logic [31:0] im_addr_o;
  logic [31:0] im_rdata_i;
  logic [31:0] instr_d_o;
  logic [31:0] pc_d_o;
  logic [31:0] pc8_d_o;
  logic        valid_d_o;
  logic        fault_d_o;

  // Environment side: hazard/redirect logic, instruction memory and decoder.
  modport master (
    output stall_i, br_taken_i, br_target_i, j_i, j_target_i, jr_i, jr_target_i,
    output im_rdata_i,
    input  im_addr_o, instr_d_o, pc_d_o, pc8_d_o, valid_d_o, fault_d_o
  );

  // Fetch unit side.
  modport slave (
    input  stall_i, br_taken_i, br_target_i, j_i, j_target_i, jr_i, jr_target_i,
    input  im_rdata_i,
    output im_addr_o, instr_d_o, pc_d_o, pc8_d_o, valid_d_o, fault_d_o
  );

endinterface

// File: rtl/fetch_pc_unit_npc_sel.sv
// Next-PC priority mux: hold > jr > j > taken branch > sequential.
module npc_sel
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        jr,
  input  logic        j,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic [31:0] j_target,
  input  logic [31:0] jr_target,
  output npc_sel_t    sel,
  output logic [31:0] npc
);

  // Pick the redirect source by fixed priority so simultaneous requests resolve deterministically.
  always_comb begin
    sel = PC4;
    if (stall)         sel = HOLD;
    else if (jr)       sel = JR;
    else if (j)        sel = J;
    else if (br_taken) sel = BR;
  end

  // Form the next PC for the chosen source; targets are taken verbatim, sequential wraps mod 2^32.
  always_comb begin
    npc = pc + 32'd4;
    unique case (sel)
      HOLD:    npc = pc;
      JR:      npc = jr_target;
      J:       npc = j_target;
      BR:      npc = br_target;
      default: npc = pc + 32'd4;
    endcase
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: architectural PC, IM address, fault check and F/D register.
module fetch_pc_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned IM_WORDS = 4096
) (
  input logic           clk,
  input logic           reset,
  fetch_pc_unit_if.slave bus
);

  localparam logic [32:0] IM_BYTES = 33'(IM_WORDS) << 2;

  logic [31:0] pc;
  logic [31:0] npc;
  npc_sel_t    sel;
  logic [32:0] pc_off;
  logic        fault;

  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic        valid_d;
  logic        fault_d;

  npc_sel u_npc_sel (
    .pc        (pc),
    .stall     (bus.stall_i),
    .jr        (bus.jr_i),
    .j         (bus.j_i),
    .br_taken  (bus.br_taken_i),
    .br_target (bus.br_target_i),
    .j_target  (bus.j_target_i),
    .jr_target (bus.jr_target_i),
    .sel       (sel),
    .npc       (npc)
  );

  // Offset from the reset vector in 33 bits: a borrow or any value past the
  // IM size means the PC lies outside the fetchable window, including after wrap.
  always_comb begin
    pc_off = {1'b0, pc} - {1'b0, RESET_PC};
    fault  = (pc[1:0] != 2'b00) || pc_off[32] || (pc_off >= IM_BYTES);
  end

  // PC register: reset vector on reset, otherwise the selected next PC (HOLD keeps it).
  always_ff @(posedge clk) begin
    if (reset)            pc <= RESET_PC;
    else if (sel != HOLD) pc <= npc;
  end

  // F/D register: capture the fetched word (nop on fault) unless stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_d <= '0;
      pc_d    <= '0;
      valid_d <= 1'b0;
      fault_d <= 1'b0;
    end else if (!bus.stall_i) begin
      instr_d <= fault ? NOP : bus.im_rdata_i;
      pc_d    <= pc;
      valid_d <= 1'b1;
      fault_d <= fault;
    end
  end

  // Drive the memory address and D-stage outputs; link address derived from pc_d.
  always_comb begin
    bus.im_addr_o = pc;
    bus.instr_d_o = instr_d;
    bus.pc_d_o    = pc_d;
    bus.pc8_d_o   = pc_d + 32'd8;
    bus.valid_d_o = valid_d;
    bus.fault_d_o = fault_d;
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: vector table with scoreboard plus a small-IM range check.
module tb_fetch_pc_unit;

  logic clk;
  logic rst;
  logic rst2;

  fetch_pc_unit_if bus ();
  fetch_pc_unit_if bus2 ();

  fetch_pc_unit #(.RESET_PC(32'h0000_3000), .IM_WORDS(4096)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  fetch_pc_unit #(.RESET_PC(32'h0000_3000), .IM_WORDS(4)) dut_small (
    .clk   (clk),
    .reset (rst2),
    .bus   (bus2.slave)
  );

  function automatic logic [31:0] imem(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign bus.im_rdata_i  = imem(bus.im_addr_o);
  assign bus2.im_rdata_i = imem(bus2.im_addr_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] brt;
    logic        j;
    logic [31:0] jt;
    logic        jr;
    logic [31:0] jrt;
    logic [31:0] e_pc;
    logic [31:0] e_pcd;
    logic        e_v;
    logic        e_f;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pcd;
    logic [31:0] instr;
    logic [31:0] pc8;
    logic        v;
    logic        f;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_chk;
  int   n_fail;

  function automatic vec_t mk(input logic r, input logic s,
                              input logic b, input logic [31:0] bt,
                              input logic jj, input logic [31:0] jjt,
                              input logic rr, input logic [31:0] rrt,
                              input logic [31:0] epc, input logic [31:0] epcd,
                              input logic ev, input logic ef);
    vec_t v;
    v.rst = r; v.stall = s; v.br = b; v.brt = bt; v.j = jj; v.jt = jjt;
    v.jr = rr; v.jrt = rrt; v.e_pc = epc; v.e_pcd = epcd; v.e_v = ev; v.e_f = ef;
    return v;
  endfunction

  function automatic exp_t expect_of(input vec_t v);
    exp_t e;
    e.pc    = v.e_pc;
    e.pcd   = v.e_pcd;
    e.instr = (v.e_v && !v.e_f) ? imem(v.e_pcd) : 32'h0;
    e.pc8   = v.e_pcd + 32'd8;
    e.v     = v.e_v;
    e.f     = v.e_f;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_main(input int idx, input exp_t e);
    chk($sformatf("v%0d im_addr", idx), bus.im_addr_o, e.pc);
    chk($sformatf("v%0d pc_d", idx), bus.pc_d_o, e.pcd);
    chk($sformatf("v%0d instr_d", idx), bus.instr_d_o, e.instr);
    chk($sformatf("v%0d pc8_d", idx), bus.pc8_d_o, e.pc8);
    chk($sformatf("v%0d valid_d", idx), {31'b0, bus.valid_d_o}, {31'b0, e.v});
    chk($sformatf("v%0d fault_d", idx), {31'b0, bus.fault_d_o}, {31'b0, e.f});
  endtask

  task automatic drive(input vec_t v);
    rst             = v.rst;
    bus.stall_i     = v.stall;
    bus.br_taken_i  = v.br;
    bus.br_target_i = v.brt;
    bus.j_i         = v.j;
    bus.j_target_i  = v.jt;
    bus.jr_i        = v.jr;
    bus.jr_target_i = v.jrt;
  endtask

  initial begin
    exp_t e;
    n_chk  = 0;
    n_fail = 0;

    rst  = 1'b1;
    rst2 = 1'b1;
    bus.stall_i = 1'b0; bus.br_taken_i = 1'b0; bus.br_target_i = '0;
    bus.j_i = 1'b0; bus.j_target_i = '0; bus.jr_i = 1'b0; bus.jr_target_i = '0;
    bus2.stall_i = 1'b0; bus2.br_taken_i = 1'b0; bus2.br_target_i = '0;
    bus2.j_i = 1'b0; bus2.j_target_i = '0; bus2.jr_i = 1'b0; bus2.jr_target_i = '0;

    //            rst st br brt            j  jt             jr jrt            pc             pc_d           v  f
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0000_3000, 32'h0,         0, 0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0000_3000, 32'h0,         0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0000_3004, 32'h0000_3000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0000_3008, 32'h0000_3004, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0000_300C, 32'h0000_3008, 1, 0));
    // jump with delay slot 0x300C
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h0000_3100, 0, 32'h0,       32'h0000_3100, 32'h0000_300C, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0000_3104, 32'h0000_3100, 1, 0));
    // three-cycle stall with pending branch, then release
    vecs.push_back(mk(0, 1, 1, 32'h0000_3400, 0, 32'h0,       0, 32'h0,        32'h0000_3104, 32'h0000_3100, 1, 0));
    vecs.push_back(mk(0, 1, 1, 32'h0000_3400, 0, 32'h0,       0, 32'h0,        32'h0000_3104, 32'h0000_3100, 1, 0));
    vecs.push_back(mk(0, 1, 1, 32'h0000_3400, 0, 32'h0,       0, 32'h0,        32'h0000_3104, 32'h0000_3100, 1, 0));
    vecs.push_back(mk(0, 0, 1, 32'h0000_3400, 0, 32'h0,       0, 32'h0,        32'h0000_3400, 32'h0000_3104, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0000_3404, 32'h0000_3400, 1, 0));
    // jr beats j
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h0000_3300, 1, 32'h0000_3200, 32'h0000_3200, 32'h0000_3404, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0000_3204, 32'h0000_3200, 1, 0));
    // j beats branch
    vecs.push_back(mk(0, 0, 1, 32'h0000_3500, 1, 32'h0000_3600, 0, 32'h0,      32'h0000_3600, 32'h0000_3204, 1, 0));
    // misaligned jr target
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_3002, 32'h0000_3002, 32'h0000_3600, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0000_3006, 32'h0000_3002, 1, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0000_300A, 32'h0000_3006, 1, 1));
    vecs.push_back(mk(0, 0, 1, 32'h0000_3000, 0, 32'h0,       0, 32'h0,        32'h0000_3000, 32'h0000_300A, 1, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0000_3004, 32'h0000_3000, 1, 0));
    // reset during a stall with a pending jr
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0000_3800, 32'h0000_3004, 32'h0000_3000, 1, 0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0000_3800, 32'h0000_3000, 32'h0,         0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0000_3004, 32'h0000_3000, 1, 0));
    // below the fetch window
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_2FFC, 32'h0000_2FFC, 32'h0000_3004, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0000_3000, 32'h0000_2FFC, 1, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0000_3004, 32'h0000_3000, 1, 0));
    // 32-bit wrap
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_3004, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0000_0000, 32'hFFFF_FFFC, 1, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0000_0004, 32'h0000_0000, 1, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h0000_3000, 0, 32'h0,       32'h0000_3000, 32'h0000_0004, 1, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0000_3004, 32'h0000_3000, 1, 0));
    // top of the window: last legal word 0x6FFC, 0x7000 faults; stall keeps the fault
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0000_6FFC, 32'h0000_6FFC, 32'h0000_3004, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0000_7000, 32'h0000_6FFC, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0000_7004, 32'h0000_7000, 1, 1));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0000_7004, 32'h0000_7000, 1, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      sb.push_back(expect_of(vecs[i]));
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard v%0d: got empty queue expected one entry", i);
      end else begin
        e = sb.pop_front();
        check_main(i, e);
      end
    end

    // Small IM (4 words): 0x3000..0x300C legal, 0x3010 and beyond fault.
    @(negedge clk);
    rst2 = 1'b1;
    @(posedge clk);
    #1;
    chk("small reset pc", bus2.im_addr_o, 32'h0000_3000);
    chk("small reset valid", {31'b0, bus2.valid_d_o}, 32'h0);
    @(negedge clk);
    rst2 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      logic [31:0] a;
      logic        f;
      a = 32'h0000_3000 + 32'(k) * 32'd4;
      f = (k >= 4);
      @(posedge clk);
      #1;
      chk($sformatf("small%0d pc_d", k), bus2.pc_d_o, a);
      chk($sformatf("small%0d fault_d", k), {31'b0, bus2.fault_d_o}, {31'b0, f});
      chk($sformatf("small%0d instr_d", k), bus2.instr_d_o, f ? 32'h0 : imem(a));
      chk($sformatf("small%0d valid_d", k), {31'b0, bus2.valid_d_o}, 32'h1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
